aging_table_manager: RTL
========================

# aging_table_manager

Owns the connection aging table of UniMan. It answers the time-out inspector's read and clear requests with a fixed 2-cycle read latency, and applies insert, refresh and delete updates from the packet path. It also generates the free-running `cur_timestamp` that both sides compare against. It sits between the flow-classification path and the connection time-out inspector.

## Interface
Parameters:
- `w_agingTb`, 17: entry width; bit 16 = valid, [15:0] = timestamp.
- `d_agingTb`, 3: index width; the table holds 2^d_agingTb entries.
- `w_timestamp`, 16: timestamp width.
- `CLK_PER_TICK`, 125000: clk cycles per timestamp tick (1 ms at 125 MHz).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `idx_agingTb` in d_agingTb: inspector index.
- `data_agingTb` in w_agingTb: inspector write data.
- `rdValid_agingTb` in 1: inspector read strobe, 1 cycle.
- `wrValid_agingTb` in 1: inspector write strobe.
- `ctx_agingTb` out w_agingTb: read result.
- `upd_valid` in 1: packet-path update request.
- `upd_op` in 1: 0 = insert/refresh, 1 = delete.
- `upd_idx` in d_agingTb: connection index.
- `upd_ready` out 1: update accepted when both valid and ready are high.
- `cur_timestamp` out w_timestamp: current time in ticks.
- `init_done` out 1: table clear sweep complete.

## Operation
- States: INIT_S, RUN_S. Reset enters INIT_S.
- INIT_S: writes 0 to entries 0 .. 2^d_agingTb-1, one per cycle, via the internal sweep counter. Inspector reads and writes are ignored. `upd_ready` = 0. After the last entry: `init_done` <= 1 and the state moves to RUN_S.
- RUN_S: one write port with fixed priority.
  - Inspector write has priority. If `wrValid_agingTb`=1, write `data_agingTb` to `idx_agingTb`.
  - Otherwise an accepted update writes to `upd_idx`:
    - insert/refresh writes {1'b1, cur_timestamp};
    - delete writes all-zero.
- `upd_ready` = (state==RUN_S) && !wrValid_agingTb. It is combinational and depends on `wrValid_agingTb`.
- Index 0 is reserved. Updates with `upd_idx`==0 are accepted (ready honoured) and dropped. Inspector writes to index 0 are executed.
- Read port is independent of the write port. A `rdValid_agingTb` sampled in RUN_S loads `ctx_agingTb` two edges later.
- Read/write to the same index on the same edge: read returns the newly written data (write-first).
- Timestamp: the tick counter counts 0..CLK_PER_TICK-1. On wrap, `cur_timestamp` += 1, modulo 2^w_timestamp (wraps 0xFFFF -> 0x0000).
- The timestamp runs during INIT_S.

## Timing
- Reset values:
  - `ctx_agingTb`=0, `upd_ready`=0, `cur_timestamp`=0, `init_done`=0;
  - tick counter=0, sweep counter=0, read pipeline=0.
- Reset asserted mid-operation restarts INIT_S. The table contents are then undefined until the sweep completes.
- INIT_S lasts exactly 2^d_agingTb cycles after reset deassertion. `upd_ready` may first be 1 in the following cycle.
- Read latency: strobe sampled at edge E0 -> RAM output register at E1 -> `ctx_agingTb` valid after E2. `ctx_agingTb` holds until the next read result; the inspector samples it at E3.
- Writes take effect at the accepting edge and are visible to any read sampled at that edge or later.
- Insert/refresh stores the `cur_timestamp` value present in the accepting cycle. If a tick wraps on that edge, the pre-increment value is stored.
- Read strobes may arrive back to back, one per cycle. The result order follows the request order.

## Structure
- Shared package `uniman_pkg` holds:
  - `w_agingTb`, `d_agingTb`, `w_timestamp`;
  - entry field positions (valid bit 16, timestamp [15:0]);
  - `UPD_INSERT`=1'b0, `UPD_DELETE`=1'b1;
  - the state encodings.
- One sub-module, `agingTb_ram`: 1 write / 1 read port, registered read, write-first bypass, with no reset on the array.
- The FSM, arbiter and timestamp counter stay in the top module.

## Test plan
- Reset with CLK_PER_TICK=4, d=3:
  - `upd_ready`=0 for 8 cycles, then 1;
  - `init_done` rises on cycle 8;
  - reads of all indices return 0.
- Insert, then read:
  - at `cur_timestamp`=5, insert idx 3;
  - a read of idx 3 two edges later gives `ctx_agingTb`=0x10005;
  - delete idx 3, then re-read gives 0.
- Collision on the write port:
  - `wrValid_agingTb`=1 (idx 2, data 0) in the same cycle as `upd_valid` (idx 5);
  - `upd_ready`=0, idx 2 is cleared, and idx 5 is written one cycle later.
- Update to idx 0 is accepted and dropped: a read of idx 0 stays 0.
- Same-index read and write on one edge:
  - refresh idx 4 while the inspector reads idx 4;
  - `ctx_agingTb` shows the new timestamp.
- Timestamp wrap:
  - force 0xFFFF; the next tick gives 0x0000;
  - an insert in that cycle stores the value current at the accepting edge.
- Reset asserted mid-RUN_S with a read in flight:
  - all outputs return to reset values;
  - INIT_S repeats.

Source files
------------

// File: rtl/uniman_pkg.sv
// uniman_pkg
// Shared definitions for the UniMan connection aging table: table
// geometry, entry field positions, packet-path update opcodes and the
// aging table manager state encoding.
package uniman_pkg;

  localparam int w_agingTb   = 17;
  localparam int d_agingTb   = 3;
  localparam int w_timestamp = 16;

  // Entry layout: {valid, timestamp}
  localparam int AGE_VALID_BIT = 16;
  localparam int AGE_TS_MSB    = 15;
  localparam int AGE_TS_LSB    = 0;

  localparam logic UPD_INSERT = 1'b0;
  localparam logic UPD_DELETE = 1'b1;

  typedef enum logic {
    INIT_S = 1'b0,
    RUN_S  = 1'b1
  } agingState_t;

endpackage

// File: rtl/agingTb_ram.sv
// agingTb_ram
// Storage array for the aging table. One write port, one read port with a
// registered read. A read and a write to the same address on the same edge
// returns the data being written, so a write is visible to any read sampled
// at its own edge. The array itself is not reset.
//
// Ports:
//   i_clk    - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_re     - read enable; loads o_rdata on the next edge
//   i_raddr  - read address
//   o_rdata  - registered read data
module agingTb_ram #(
  parameter int W = 17,
  parameter int D = 3
) (
  input  logic         i_clk,
  input  logic         i_we,
  input  logic [D-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_re,
  input  logic [D-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);

  logic [W-1:0] r_mem [0:(1<<D)-1];
  logic [W-1:0] r_rdata;

  // Write-first: a same-address write on the read edge bypasses the array.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/aging_table_manager.sv
// aging_table_manager
// Owns the connection aging table. After reset it sweeps every entry to
// zero, then serves inspector reads (fixed 2-edge latency to ctx_agingTb)
// and arbitrates one write port between inspector writes (priority) and
// packet-path insert/refresh/delete updates. Also produces the free-running
// millisecond timestamp that entries are stamped with.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   idx_agingTb       - inspector index (read and write)
//   data_agingTb      - inspector write data
//   rdValid_agingTb   - inspector read strobe
//   wrValid_agingTb   - inspector write strobe
//   ctx_agingTb       - inspector read result, holds until the next result
//   upd_valid/op/idx  - packet-path update request
//   upd_ready         - update accepted when valid && ready
//   cur_timestamp     - current time in ticks
//   init_done         - clear sweep finished
module aging_table_manager
  import uniman_pkg::agingState_t, uniman_pkg::INIT_S, uniman_pkg::RUN_S,
         uniman_pkg::UPD_INSERT, uniman_pkg::AGE_VALID_BIT,
         uniman_pkg::AGE_TS_MSB, uniman_pkg::AGE_TS_LSB;
#(
  parameter int w_agingTb    = uniman_pkg::w_agingTb,
  parameter int d_agingTb    = uniman_pkg::d_agingTb,
  parameter int w_timestamp  = uniman_pkg::w_timestamp,
  parameter int CLK_PER_TICK = 125000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [d_agingTb-1:0]   idx_agingTb,
  input  logic [w_agingTb-1:0]   data_agingTb,
  input  logic                   rdValid_agingTb,
  input  logic                   wrValid_agingTb,
  output logic [w_agingTb-1:0]   ctx_agingTb,
  input  logic                   upd_valid,
  input  logic                   upd_op,
  input  logic [d_agingTb-1:0]   upd_idx,
  output logic                   upd_ready,
  output logic [w_timestamp-1:0] cur_timestamp,
  output logic                   init_done
);

  localparam int TICK_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  agingState_t            r_state;
  agingState_t            w_stateNext;
  logic [d_agingTb-1:0]   r_sweepIdx;
  logic                   r_initDone;
  logic [TICK_W-1:0]      r_tickCnt;
  logic [w_timestamp-1:0] r_timestamp;
  logic                   r_rdVld1;
  logic                   r_rdVld2;
  logic [w_agingTb-1:0]   r_rdData2;
  logic [w_agingTb-1:0]   r_ctx;

  logic                   w_sweepLast;
  logic                   w_tickWrap;
  logic                   w_rdFire;
  logic                   w_updReady;
  logic                   w_we;
  logic [d_agingTb-1:0]   w_waddr;
  logic [w_agingTb-1:0]   w_wdata;
  logic [w_agingTb-1:0]   w_ramQ;

  assign w_sweepLast = (r_sweepIdx == {d_agingTb{1'b1}});
  assign w_tickWrap  = (r_tickCnt == TICK_W'(CLK_PER_TICK - 1));
  assign w_rdFire    = rdValid_agingTb && (r_state == RUN_S);

  // State register plus sweep counter; init_done latches on the last sweep write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= INIT_S;
      r_sweepIdx <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == INIT_S) begin
        r_sweepIdx <= r_sweepIdx + 1'b1;
        if (w_sweepLast) begin
          r_initDone <= 1'b1;
        end
      end
    end
  end

  // Next state and write-port arbitration. Inspector writes win; an update
  // is only ready when no inspector write is present. Updates to the
  // reserved index 0 are accepted but never reach the array.
  always_comb begin
    w_stateNext = r_state;
    w_updReady  = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    case (r_state)
      INIT_S: begin
        w_we    = 1'b1;
        w_waddr = r_sweepIdx;
        if (w_sweepLast) begin
          w_stateNext = RUN_S;
        end
      end
      RUN_S: begin
        w_updReady = !wrValid_agingTb;
        if (wrValid_agingTb) begin
          w_we    = 1'b1;
          w_waddr = idx_agingTb;
          w_wdata = data_agingTb;
        end else if (upd_valid && (upd_idx != '0)) begin
          w_we    = 1'b1;
          w_waddr = upd_idx;
          if (upd_op == UPD_INSERT) begin
            w_wdata[AGE_VALID_BIT]          = 1'b1;
            w_wdata[AGE_TS_MSB:AGE_TS_LSB]  = r_timestamp;
          end
        end
      end
    endcase
  end

  // Tick prescaler and timestamp; wraps naturally modulo 2^w_timestamp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tickCnt   <= '0;
      r_timestamp <= '0;
    end else if (w_tickWrap) begin
      r_tickCnt   <= '0;
      r_timestamp <= r_timestamp + 1'b1;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  agingTb_ram #(
    .W (w_agingTb),
    .D (d_agingTb)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rdFire),
    .i_raddr (idx_agingTb),
    .o_rdata (w_ramQ)
  );

  // Read pipeline: RAM register at E0, staging at E1, ctx at E2.
  // Valid bits are reset so an in-flight read is dropped by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdVld1  <= 1'b0;
      r_rdVld2  <= 1'b0;
      r_rdData2 <= '0;
      r_ctx     <= '0;
    end else begin
      r_rdVld1 <= w_rdFire;
      r_rdVld2 <= r_rdVld1;
      if (r_rdVld1) begin
        r_rdData2 <= w_ramQ;
      end
      if (r_rdVld2) begin
        r_ctx <= r_rdData2;
      end
    end
  end

  assign ctx_agingTb   = r_ctx;
  assign upd_ready     = w_updReady;
  assign cur_timestamp = r_timestamp;
  assign init_done     = r_initDone;

endmodule
